mmu_feeder_n: RTL and testbench

- Parametrised N×N operand feeder and result collector for the output-stationary systolic MMU.
- Latches an N×N weight matrix A and an N×N input matrix B on `start`.
- Streams them into the array with diagonal skew (row i of A and column j of B delayed by i and j cycles), then waits a drain period and snapshots all N*N accumulators.
- Exposes the snapshot to the RPi host through a byte-wide readback port with byte-select and signed-saturate modes.

---
 rtl/mmu_feeder_n.sv | 203 ++++++++++++++++++++
 tb/tb_mmu_feeder_n.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmu_feeder_n.sv
// mmu_feeder_n
//   Operand feeder and result collector for an N x N output-stationary
//   systolic MMU. On start it latches matrices A (weights) and B (inputs),
//   streams row i of A and column j of B into the array skewed by i / j
//   cycles, waits a drain period, then snapshots every accumulator. The host
//   reads the snapshot back one byte at a time, either as a raw byte slice
//   or as a signed value clamped to 8 bits.
//
// Ports
//   clk_i, rst_n_i     clock, synchronous active-low reset
//   en_i               block enable; low forces IDLE
//   start_i, ack_i     begin a multiply / acknowledge DONE
//   sat_mode_i         1: signed-saturated readback, 0: byte slice
//   output_sel_i       result index r*N+c
//   byte_sel_i         byte of the selected result, 0 = LSB
//   weights_flat_i     A, element r*N+c at [(r*N+c)*DW +: DW]
//   inputs_flat_i      B, same packing
//   c_flat_i           array accumulators, same packing (AW each)
//   clear_o            accumulator clear to the array
//   a_data_o, b_data_o row / column operands (registered)
//   busy_o, done_o     CLEAR/FEED/DRAIN, DONE
//   host_outdata_o     registered readback byte
module mmu_feeder_n #(
    parameter int N     = 2,
    parameter int DW    = 8,
    parameter int AW    = 16,
    parameter int DRAIN = N + 1
) (
    input  logic                                      clk_i,
    input  logic                                      rst_n_i,
    input  logic                                      en_i,
    input  logic                                      start_i,
    input  logic                                      ack_i,
    input  logic                                      sat_mode_i,
    input  logic [$clog2(N*N)-1:0]                    output_sel_i,
    input  logic [((AW/8) > 1 ? $clog2(AW/8) : 1)-1:0] byte_sel_i,
    input  logic [N*N*DW-1:0]                         weights_flat_i,
    input  logic [N*N*DW-1:0]                         inputs_flat_i,
    input  logic [N*N*AW-1:0]                         c_flat_i,
    output logic                                      clear_o,
    output logic [N*DW-1:0]                           a_data_o,
    output logic [N*DW-1:0]                           b_data_o,
    output logic                                      busy_o,
    output logic                                      done_o,
    output logic [7:0]                                host_outdata_o
);

    localparam int NE   = N * N;
    localparam int NB   = AW / 8;
    localparam int KMAX = (2*N - 1 > DRAIN) ? 2*N - 1 : DRAIN;
    localparam int CW   = $clog2(KMAX + 1);

    localparam logic [CW-1:0] K_FEED_LAST  = CW'(2*N - 2);
    localparam logic [CW-1:0] K_DRAIN_LAST = CW'(DRAIN - 1);

    localparam logic signed [AW-1:0] SAT_HI = AW'(127);
    localparam logic signed [AW-1:0] SAT_LO = AW'(-128);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FEED,
        S_DRAIN,
        S_DONE
    } state_e;

    state_e                  state_q, state_d;
    logic [CW-1:0]           k_q, k_d;
    logic                    load, capture;

    logic [NE-1:0][DW-1:0]   a_mat_q, b_mat_q;
    logic [NE-1:0][AW-1:0]   snap_q;
    logic [N-1:0][DW-1:0]    a_q, a_d, b_q, b_d;
    logic [7:0]              host_q, host_d;

    logic [AW-1:0]           sel_v;
    logic [7:0]              byte_v, sat_v;

    // Next state, step counter and state-decoded outputs
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        load    = 1'b0;
        capture = 1'b0;
        clear_o = 1'b0;
        busy_o  = 1'b0;
        done_o  = 1'b0;

        case (state_q)
            S_IDLE:  clear_o = 1'b1;
            S_CLEAR: begin clear_o = 1'b1; busy_o = 1'b1; end
            S_FEED:  busy_o = 1'b1;
            S_DRAIN: busy_o = 1'b1;
            S_DONE:  done_o = 1'b1;
            default: clear_o = 1'b1;
        endcase

        if (!en_i) begin
            state_d = S_IDLE;
            k_d     = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_CLEAR;
                        load    = 1'b1;
                    end
                end
                S_CLEAR: begin
                    state_d = S_FEED;
                    k_d     = '0;
                end
                S_FEED: begin
                    if (k_q == K_FEED_LAST) begin
                        state_d = S_DRAIN;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
                S_DRAIN: begin
                    if (k_q == K_DRAIN_LAST) begin
                        state_d = S_DONE;
                        k_d     = '0;
                        capture = 1'b1;
                    end else begin
                        k_d = k_q + CW'(1);
                    end
                end
                S_DONE: begin
                    // start wins over ack
                    if (start_i) begin
                        state_d = S_CLEAR;
                        load    = 1'b1;
                    end else if (ack_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Skewed operand select: lane i carries A[i][m] and B[m][i] on step k = i+m.
    always_comb begin
        a_d = '0;
        b_d = '0;
        if (en_i && state_q == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                for (int m = 0; m < N; m++) begin
                    if (int'(k_q) == i + m) begin
                        a_d[i] = a_mat_q[i*N + m];
                        b_d[i] = b_mat_q[m*N + i];
                    end
                end
            end
        end
    end

    // Readback byte
    always_comb begin
        sel_v  = snap_q[output_sel_i];
        byte_v = '0;
        for (int b = 0; b < NB; b++) begin
            if (int'(byte_sel_i) == b) byte_v = sel_v[b*8 +: 8];
        end
        if ($signed(sel_v) > SAT_HI)      sat_v = 8'h7F;
        else if ($signed(sel_v) < SAT_LO) sat_v = 8'h80;
        else                              sat_v = sel_v[7:0];

        host_d = '0;
        if (en_i && int'(output_sel_i) < NE) host_d = sat_mode_i ? sat_v : byte_v;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            a_mat_q <= '0;
            b_mat_q <= '0;
            snap_q  <= '0;
            host_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            b_q     <= b_d;
            host_q  <= host_d;
            if (load) begin
                a_mat_q <= weights_flat_i;
                b_mat_q <= inputs_flat_i;
            end
            if (capture) snap_q <= c_flat_i;
        end
    end

    assign a_data_o       = a_q;
    assign b_data_o       = b_q;
    assign host_outdata_o = host_q;

endmodule

// File: tb/tb_mmu_feeder_n.sv
// Bench for mmu_feeder_n: an N=2 and an N=4 instance, each driving a
// behavioural output-stationary MAC array (PE(i,j) sees row operand i
// delayed j cycles and column operand j delayed i cycles). Results are
// compared with a plain matrix product.
module tb_mmu_feeder_n;
    localparam int DW = 8, AW = 16, N2 = 2, N4 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int n_chk, n_pass;

    // ---------------- N=2 instance ----------------
    logic en2, start2, ack2, sat2;
    logic [1:0] sel2;
    logic [0:0] bs2;
    logic [N2*N2*DW-1:0] w2, x2;
    logic [N2*N2*AW-1:0] c2, c2_arr, c2_ovr;
    logic ovr2;
    logic clr2, busy2, done2;
    logic [N2*DW-1:0] a2, b2;
    logic [7:0] h2;

    mmu_feeder_n dut2 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en2), .start_i(start2), .ack_i(ack2),
        .sat_mode_i(sat2), .output_sel_i(sel2), .byte_sel_i(bs2),
        .weights_flat_i(w2), .inputs_flat_i(x2), .c_flat_i(c2),
        .clear_o(clr2), .a_data_o(a2), .b_data_o(b2), .busy_o(busy2),
        .done_o(done2), .host_outdata_o(h2));

    // ---------------- N=4 instance ----------------
    logic en4, start4, ack4, sat4;
    logic [3:0] sel4;
    logic [0:0] bs4;
    logic [N4*N4*DW-1:0] w4, x4;
    logic [N4*N4*AW-1:0] c4;
    logic clr4, busy4, done4;
    logic [N4*DW-1:0] a4, b4;
    logic [7:0] h4;

    mmu_feeder_n #(.N(4), .DRAIN(5)) dut4 (
        .clk_i(clk), .rst_n_i(rst_n), .en_i(en4), .start_i(start4), .ack_i(ack4),
        .sat_mode_i(sat4), .output_sel_i(sel4), .byte_sel_i(bs4),
        .weights_flat_i(w4), .inputs_flat_i(x4), .c_flat_i(c4),
        .clear_o(clr4), .a_data_o(a4), .b_data_o(b4), .busy_o(busy4),
        .done_o(done4), .host_outdata_o(h4));

    function automatic int el(logic [N4*DW-1:0] v, int i);
        logic signed [DW-1:0] e;
        e = v[i*DW +: DW];
        return int'(e);
    endfunction

    // ---------------- MAC array models ----------------
    // xh[d][i] = operand on lane i, d cycles ago; xc adds the current value at d=0
    int ah2 [N2][N2], bh2 [N2][N2], ac2 [N2][N2], bc2 [N2][N2], acc2 [N2][N2];
    always_comb begin
        for (int d = 0; d < N2; d++)
            for (int i = 0; i < N2; i++) begin
                ac2[d][i] = (d == 0) ? el(32'(a2), i) : ah2[d][i];
                bc2[d][i] = (d == 0) ? el(32'(b2), i) : bh2[d][i];
            end
    end
    always @(posedge clk) begin
        for (int d = 1; d < N2; d++)
            for (int i = 0; i < N2; i++) begin
                ah2[d][i] <= ac2[d-1][i];
                bh2[d][i] <= bc2[d-1][i];
            end
        for (int i = 0; i < N2; i++)
            for (int j = 0; j < N2; j++)
                acc2[i][j] <= clr2 ? 0 : acc2[i][j] + ac2[j][i] * bc2[i][j];
    end
    always_comb begin
        c2_arr = '0;
        for (int i = 0; i < N2; i++)
            for (int j = 0; j < N2; j++) c2_arr[(i*N2+j)*AW +: AW] = AW'(acc2[i][j]);
    end
    assign c2 = ovr2 ? c2_ovr : c2_arr;

    int ah4 [N4][N4], bh4 [N4][N4], ac4 [N4][N4], bc4 [N4][N4], acc4 [N4][N4];
    always_comb begin
        for (int d = 0; d < N4; d++)
            for (int i = 0; i < N4; i++) begin
                ac4[d][i] = (d == 0) ? el(a4, i) : ah4[d][i];
                bc4[d][i] = (d == 0) ? el(b4, i) : bh4[d][i];
            end
    end
    always @(posedge clk) begin
        for (int d = 1; d < N4; d++)
            for (int i = 0; i < N4; i++) begin
                ah4[d][i] <= ac4[d-1][i];
                bh4[d][i] <= bc4[d-1][i];
            end
        for (int i = 0; i < N4; i++)
            for (int j = 0; j < N4; j++)
                acc4[i][j] <= clr4 ? 0 : acc4[i][j] + ac4[j][i] * bc4[i][j];
    end
    always_comb begin
        c4 = '0;
        for (int i = 0; i < N4; i++)
            for (int j = 0; j < N4; j++) c4[(i*N4+j)*AW +: AW] = AW'(acc4[i][j]);
    end

    // ---------------- reference ----------------
    int A2 [N2][N2], B2 [N2][N2], A4 [N4][N4], B4 [N4][N4];

    function automatic logic [AW-1:0] ref2(int e);
        int s;
        s = 0;
        for (int k = 0; k < N2; k++) s += A2[e/N2][k] * B2[k][e%N2];
        return AW'(s);
    endfunction

    function automatic logic [AW-1:0] ref4(int e);
        int s;
        s = 0;
        for (int k = 0; k < N4; k++) s += A4[e/N4][k] * B4[k][e%N4];
        return AW'(s);
    endfunction

    function automatic logic [7:0] satref(logic [AW-1:0] v);
        int s;
        s = int'($signed(v));
        if (s > 127) return 8'h7F;
        if (s < -128) return 8'h80;
        return v[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack2();
        for (int r = 0; r < N2; r++)
            for (int c = 0; c < N2; c++) begin
                w2[(r*N2+c)*DW +: DW] = DW'(A2[r][c]);
                x2[(r*N2+c)*DW +: DW] = DW'(B2[r][c]);
            end
    endtask

    task automatic rand2();
        for (int r = 0; r < N2; r++)
            for (int c = 0; c < N2; c++) begin
                A2[r][c] = int'($urandom_range(0, 255)) - 128;
                B2[r][c] = int'($urandom_range(0, 255)) - 128;
            end
        pack2();
    endtask

    task automatic wait_done2(output int cnt);
        cnt = 0;
        while (done2 !== 1'b1 && cnt < 200) begin tick(); cnt++; end
    endtask

    task automatic read2(input int s, output logic [AW-1:0] v);
        sel2 = 2'(s); sat2 = 1'b0;
        bs2 = 1'b0; tick(); v[7:0]  = h2;
        bs2 = 1'b1; tick(); v[15:8] = h2;
    endtask

    task automatic read4(input int s, output logic [AW-1:0] v);
        sel4 = 4'(s); sat4 = 1'b0;
        bs4 = 1'b0; tick(); v[7:0]  = h4;
        bs4 = 1'b1; tick(); v[15:8] = h4;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1; en2 = 1'b1; en4 = 1'b1;
        tick();
        if ({clr2, busy2, done2} !== 3'b100) $display("FAIL reset_ctl2 got %b want 100", {clr2, busy2, done2}); else n_pass++; n_chk++;
        if ({a2, b2, h2} !== 40'd0) $display("FAIL reset_data2 got %h want 0", {a2, b2, h2}); else n_pass++; n_chk++;
        if ({clr4, busy4, done4} !== 3'b100) $display("FAIL reset_ctl4 got %b want 100", {clr4, busy4, done4}); else n_pass++; n_chk++;
        if ({a4, b4, h4} !== 72'd0) $display("FAIL reset_data4 got %h want 0", {a4, b4, h4}); else n_pass++; n_chk++;
    endtask

    task automatic test_feed();
        logic [15:0] ea [5];
        logic [15:0] eb [5];
        int cnt;
        ea = '{16'h0000, 16'h0001, 16'h0302, 16'h0400, 16'h0000};
        eb = '{16'h0000, 16'h0005, 16'h0607, 16'h0800, 16'h0000};
        A2 = '{'{1, 2}, '{3, 4}};
        B2 = '{'{5, 6}, '{7, 8}};
        pack2();
        start2 = 1'b1; tick(); start2 = 1'b0;
        w2 = $urandom(); x2 = $urandom();
        if ({clr2, busy2, a2, b2} !== {2'b11, 32'd0}) $display("FAIL feed_clear got %h want %h", {clr2, busy2, a2, b2}, {2'b11, 32'd0}); else n_pass++; n_chk++;
        for (int t = 0; t < 5; t++) begin
            tick();
            if ({clr2, a2, b2} !== {1'b0, ea[t], eb[t]}) $display("FAIL feed_step%0d got %h want %h", t, {clr2, a2, b2}, {1'b0, ea[t], eb[t]}); else n_pass++; n_chk++;
        end
        wait_done2(cnt);
        cnt += 5;
        if (cnt !== 7) $display("FAIL feed_latency got %0d want 7", cnt); else n_pass++; n_chk++;
    endtask

    task automatic test_e2e();
        logic [AW-1:0] r;
        logic [7:0] e;
        for (int s = 0; s < 4; s++) begin
            r = ref2(s); e = r[7:0];
            sel2 = 2'(s); bs2 = 1'b0; sat2 = 1'b0; tick();
            if (h2 !== e) $display("FAIL e2e_sel%0d got %0d want %0d", s, h2, e); else n_pass++; n_chk++;
        end
        ack2 = 1'b1; tick(); ack2 = 1'b0;
        if ({clr2, done2, busy2} !== 3'b100) $display("FAIL e2e_ack got %b want 100", {clr2, done2, busy2}); else n_pass++; n_chk++;
        sel2 = 2'd3; tick();
        if (h2 !== 8'd50) $display("FAIL e2e_after_ack got %0d want 50", h2); else n_pass++; n_chk++;
    endtask

    task automatic test_readback();
        logic [AW-1:0] e3;
        int cnt;
        int rs [8], rb [8], rt [8];
        logic [7:0] rx [8];
        e3 = AW'($urandom());
        ovr2 = 1'b1;
        c2_ovr = {e3, 16'h0005, 16'hFED4, 16'h012C};
        start2 = 1'b1; tick(); start2 = 1'b0;
        wait_done2(cnt);
        if (cnt !== 7) $display("FAIL rb_latency got %0d want 7", cnt); else n_pass++; n_chk++;
        rs = '{0, 0, 0, 1, 2, 1, 3, 3};
        rb = '{1, 0, 0, 0, 0, 1, 0, 1};
        rt = '{0, 0, 1, 1, 1, 0, 1, 0};
        rx = '{8'h01, 8'h2C, 8'h7F, 8'h80, 8'h05, 8'hFE, satref(e3), e3[15:8]};
        for (int i = 0; i < 8; i++) begin
            sel2 = 2'(rs[i]); bs2 = 1'(rb[i]); sat2 = 1'(rt[i]); tick();
            if (h2 !== rx[i]) $display("FAIL rb_case%0d got %h want %h", i, h2, rx[i]); else n_pass++; n_chk++;
        end
        en2 = 1'b0; tick();
        if ({h2, clr2, done2} !== {8'h00, 2'b10}) $display("FAIL rb_en_low got %h want %h", {h2, clr2, done2}, {8'h00, 2'b10}); else n_pass++; n_chk++;
        en2 = 1'b1; sel2 = 2'd0; bs2 = 1'b0; sat2 = 1'b0; tick();
        if (h2 !== 8'h2C) $display("FAIL rb_retained got %h want 2c", h2); else n_pass++; n_chk++;
        ovr2 = 1'b0;
    endtask

    task automatic test_abort();
        int cnt, seen;
        logic [AW-1:0] v, e;
        rand2();
        start2 = 1'b1; tick(); start2 = 1'b0;
        tick(); tick();
        en2 = 1'b0; tick();
        if ({clr2, busy2, done2, a2, b2} !== {3'b100, 32'd0}) $display("FAIL abort_idle got %h want %h", {clr2, busy2, done2, a2, b2}, {3'b100, 32'd0}); else n_pass++; n_chk++;
        seen = 0;
        for (int t = 0; t < 10; t++) begin tick(); if (done2 === 1'b1) seen = 1; end
        en2 = 1'b1; sel2 = 2'd0; bs2 = 1'b0; sat2 = 1'b0; tick();
        if (done2 === 1'b1) seen = 1;
        if (seen !== 0) $display("FAIL abort_no_done got %0d want 0", seen); else n_pass++; n_chk++;
        if (h2 !== 8'h2C) $display("FAIL abort_snapshot got %h want 2c", h2); else n_pass++; n_chk++;

        // full run with a stray start in DRAIN
        rand2();
        start2 = 1'b1; tick(); start2 = 1'b0;
        w2 = $urandom(); x2 = $urandom();
        for (int t = 0; t < 5; t++) tick();
        start2 = 1'b1; tick(); start2 = 1'b0;
        if ({busy2, clr2, done2} !== 3'b100) $display("FAIL drain_start_ignored got %b want 100", {busy2, clr2, done2}); else n_pass++; n_chk++;
        tick();
        if (done2 !== 1'b1) $display("FAIL drain_done got %b want 1", done2); else n_pass++; n_chk++;
        for (int s = 0; s < 4; s++) begin
            read2(s, v); e = ref2(s);
            if (v !== e) $display("FAIL run1_res%0d got %h want %h", s, v, e); else n_pass++; n_chk++;
        end

        // restart from DONE with ack also high
        rand2();
        start2 = 1'b1; ack2 = 1'b1; tick(); start2 = 1'b0; ack2 = 1'b0;
        w2 = $urandom(); x2 = $urandom();
        if ({clr2, busy2, done2} !== 3'b110) $display("FAIL restart_clear got %b want 110", {clr2, busy2, done2}); else n_pass++; n_chk++;
        wait_done2(cnt);
        if (cnt !== 7) $display("FAIL restart_latency got %0d want 7", cnt); else n_pass++; n_chk++;
        for (int s = 0; s < 4; s++) begin
            read2(s, v); e = ref2(s);
            if (v !== e) $display("FAIL run2_res%0d got %h want %h", s, v, e); else n_pass++; n_chk++;
        end
    endtask

    task automatic test_n4();
        int cnt;
        logic [AW-1:0] v, e;
        logic [7:0] se;
        for (int it = 0; it < 2; it++) begin
            for (int r = 0; r < N4; r++)
                for (int c = 0; c < N4; c++) begin
                    A4[r][c] = int'($urandom_range(0, 255)) - 128;
                    B4[r][c] = int'($urandom_range(0, 255)) - 128;
                    w4[(r*N4+c)*DW +: DW] = DW'(A4[r][c]);
                    x4[(r*N4+c)*DW +: DW] = DW'(B4[r][c]);
                end
            start4 = 1'b1; tick(); start4 = 1'b0;
            w4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            x4 = {$urandom(), $urandom(), $urandom(), $urandom()};
            cnt = 0;
            while (done4 !== 1'b1 && cnt < 200) begin tick(); cnt++; end
            if (cnt !== 13) $display("FAIL n4_latency it%0d got %0d want 13", it, cnt); else n_pass++; n_chk++;
            for (int s = 0; s < N4*N4; s++) begin
                read4(s, v); e = ref4(s);
                if (v !== e) $display("FAIL n4_res it%0d sel%0d got %h want %h", it, s, v, e); else n_pass++; n_chk++;
            end
            e = ref4(5); se = satref(e);
            sel4 = 4'd5; sat4 = 1'b1; tick(); sat4 = 1'b0;
            if (h4 !== se) $display("FAIL n4_sat it%0d got %h want %h", it, h4, se); else n_pass++; n_chk++;
            ack4 = 1'b1; tick(); ack4 = 1'b0;
        end
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        rst_n = 1'b0;
        en2 = 1'b0; start2 = 1'b0; ack2 = 1'b0; sat2 = 1'b0; sel2 = '0; bs2 = '0;
        w2 = '0; x2 = '0; ovr2 = 1'b0; c2_ovr = '0;
        en4 = 1'b0; start4 = 1'b0; ack4 = 1'b0; sat4 = 1'b0; sel4 = '0; bs4 = '0;
        w4 = '0; x4 = '0;
        test_reset();
        test_feed();
        test_e2e();
        test_readback();
        test_abort();
        test_n4();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
